counter_scheduler: RTL
======================

Name: counter_scheduler

Overview:
Shares one WIDTH-bit up-counter resource among NUM_REQ requesters. Each requester asks for a counting run of a given length. The block arbitrates round-robin, grants exclusive use, runs the counter for the latched length, then signals completion. It sits in front of the counter datapath as its sole sequencer.

Parameters:
NUM_REQ, 4, number of requesters (>= 2)
WIDTH, 8, counter and run-length width in bits
ID_W, $clog2(NUM_REQ), width of the requester index (derived; not overridden)

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-low reset (reset==0 at posedge clears all state)
req  input  NUM_REQ  per-requester request level; held high until done or abort
len  input  NUM_REQ*WIDTH  flat per-requester run length; requester i uses bits [i*WIDTH +: WIDTH]
grant  output  NUM_REQ  one-hot owner of the counter; all-zero when free
active_id  output  ID_W  index of the current owner; 0 when free
count  output  WIDTH  shared counter value
busy  output  1  high in RUN and DONE
done  output  NUM_REQ  one-cycle completion pulse to the owner

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; grant=0, active_id=0, count=0, busy=0, done=0; round-robin pointer=0, so requester 0 has highest priority first. Reset mid-run aborts silently, with no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: if req != 0, select the first set bit searching ptr, ptr+1, … mod NUM_REQ. At the next edge: state=RUN, grant[i]=1, active_id=i, count=0, L=len[i] latched, busy=1. With no request, everything holds.
- RUN: each edge, if req[i]==0, abort: state=IDLE, grant=0, active_id=0, busy=0, count holds, no done, ptr=i+1. Otherwise, if count==L, go to DONE. Otherwise count<=count+1.
- Latency: req sampled at edge T gives grant at T+1 with count=0. count reaches L at T+1+L. DONE is at T+2+L.
- DONE (one cycle): done[i]=1, grant=0, busy=1, count holds L. Next edge: state=IDLE, done=0, busy=0, ptr=(i+1) mod NUM_REQ.
- L==0: RUN lasts one cycle (count=0), then DONE.
- L max (2^WIDTH-1): count never wraps, because count <= L always.
- len changes after the grant are ignored. Changes to req of non-owners during RUN/DONE are ignored.
- Arbitration happens only in IDLE. Minimum gap between consecutive grants is one IDLE cycle.
- Requester i re-asserting immediately after its own done loses to any other pending requester (pointer has moved past i).
- Owner deasserting req in the same cycle count==L: abort has priority, so there is no done.

Decomposition:
- Package counter_sched_pkg: state enum {IDLE, RUN, DONE}, state encoding width, default NUM_REQ/WIDTH constants.
- One sub-module rr_arbiter: combinational; inputs req and ptr; outputs one-hot grant_next and idx_next. The parent owns the pointer register.

Test Plan:
1. Hold reset=0 for 3 cycles with req=4'b1111 -> grant=0, count=0, busy=0, done=0 throughout. Release reset -> grant=4'b0001 one cycle later.
2. Single req[2] with len=5 -> grant=4'b0100 and count 0,1,2,3,4,5 over 6 cycles. Then done=4'b0100 for exactly 1 cycle with count=5. Then IDLE with busy=0.
3. req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0. Each grant lasts 2 cycles, followed by a 1-cycle done, then 1 IDLE cycle.
4. req[1] with len=0 -> grant 1 cycle with count=0, then done[1]. len=255 -> count reaches 255, no wrap, done at grant+256.
5. req[3] with len=10, drop req[3] when count=4 -> next cycle grant=0, busy=0, count=4, done never pulses. Next grant goes to requester 0.
6. Pull reset=0 at count=7 of a len=20 run -> next cycle all outputs are zero, no done. After release, requester 0 wins over requester 1.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types and defaults for the round-robin counter scheduler.
package counter_sched_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 8;
  localparam int STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/counter_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_next,
  output logic [ID_W-1:0]    idx_next
);
  logic found;

  always_comb begin
    grant_next = '0;
    idx_next   = '0;
    found      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found                                     = 1'b1;
        grant_next[(int'(ptr) + k) % NUM_REQ]     = 1'b1;
        idx_next                                  = ID_W'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/counter_scheduler.sv
// Sequences one shared up-counter among NUM_REQ requesters: arbitrate, run to
// the latched length, pulse done to the owner, then rotate priority.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int WIDTH   = WIDTH_DEF,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [ID_W-1:0]          active_id,
  output logic [WIDTH-1:0]         count,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       done
);
  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [WIDTH-1:0]   run_len;
  logic [NUM_REQ-1:0] grant_next;
  logic [ID_W-1:0]    idx_next;
  logic [WIDTH-1:0]   sel_len;
  logic [ID_W-1:0]    next_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req        (req),
    .ptr        (ptr),
    .grant_next (grant_next),
    .idx_next   (idx_next)
  );

  assign sel_len  = len[idx_next*WIDTH +: WIDTH];
  assign next_ptr = (active_id == ID_W'(NUM_REQ-1)) ? '0 : active_id + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grant     <= '0;
      active_id <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= '0;
      ptr       <= '0;
      run_len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= RUN;
            grant     <= grant_next;
            active_id <= idx_next;
            count     <= '0;
            run_len   <= sel_len;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          // Owner dropping req wins over reaching the end: silent abort.
          if (!req[active_id]) begin
            state     <= IDLE;
            grant     <= '0;
            active_id <= '0;
            busy      <= 1'b0;
            ptr       <= next_ptr;
          end else if (count == run_len) begin
            state <= DONE;
            done  <= grant;
            grant <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= '0;
          busy      <= 1'b0;
          active_id <= '0;
          ptr       <= next_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
